sync_filter_bus: RTL

- Parametrised successor to the single-bit synchronizer.
- Brings C_WIDTH independent asynchronous inputs into the clk domain through a C_SYNC_STAGES register chain per bit.
- Rejects glitches shorter than C_FILTER_LEN cycles with a per-bit stability counter.
- Provides the filtered level plus registered rise, fall and any-edge pulses. Used for async status pins, toggle-based CDC and external strobes.
- Bits are independent and not coherent. This block is not used for multi-bit data words; those use gray code or a handshake.

---
 rtl/sync_filter_channel.sv | 137 +++++++++++++
 rtl/sync_filter_bus.sv | 63 ++++++
 2 files changed

// File: rtl/sync_filter_channel.sv
// -----------------------------------------------------------------------------
// sync_filter_channel
//
// One bit of the synchronizing glitch filter.  An asynchronous input is brought
// into the clk domain through a C_SYNC_STAGES flop chain, qualified by a
// stability counter so that short glitches never reach the output, and turned
// into a filtered level plus registered rise / fall / any-edge pulses.
//
// Ports:
//   clk     input   destination clock
//   rstn    input   asynchronous active-low reset (release must be synchronous
//                   to clk upstream; it is not re-synchronized here)
//   d_i     input   asynchronous input bit
//   q_o     output  synchronized, filtered level
//   rise_o  output  one-cycle pulse in the first cycle q_o shows 1 after a 0
//   fall_o  output  one-cycle pulse in the first cycle q_o shows 0 after a 1
//   edge_o  output  rise_o | fall_o
// -----------------------------------------------------------------------------
module sync_filter_channel #(
  parameter int unsigned C_SYNC_STAGES = 3,
  parameter int unsigned C_FILTER_LEN  = 1,
  parameter logic        C_RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o,
  output logic edge_o
);

  // The counter must hold 0 .. C_FILTER_LEN-1; sizing it from C_FILTER_LEN+1
  // keeps the width at least one bit even when filtering is disabled.
  localparam int unsigned      CNT_W    = $clog2(C_FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_FILTER_LEN - 1);

  // Metastability chain.  The attributes keep the flops packed together and
  // stop the tools from folding the chain into an SRL, which would destroy the
  // resolution time between stages.
  (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "no" *)
  logic [C_SYNC_STAGES-1:0] syncChain_q;

  logic             syncBit;
  logic             sample_q;
  logic             filt_q;
  logic             filt_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             rise_q;
  logic             rise_d;
  logic             fall_q;
  logic             fall_d;
  logic             edge_q;
  logic             edge_d;

  // Shift the raw input through the synchronizer.  Bit 0 is the capture flop
  // and the top bit is the first value that is safe to use in clk logic.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      syncChain_q <= {C_SYNC_STAGES{C_RESET_VAL}};
    end else if (C_SYNC_STAGES > 1) begin
      syncChain_q <= {syncChain_q[C_SYNC_STAGES-2:0], d_i};
    end else begin
      syncChain_q <= d_i;
    end
  end

  assign syncBit = syncChain_q[C_SYNC_STAGES-1];

  // The filter works on a registered copy of the synchronized bit.  This keeps
  // the last chain flop driving a single load, and it makes the total delay
  // from capture to a flipped output exactly C_SYNC_STAGES + C_FILTER_LEN.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sample_q <= C_RESET_VAL;
    end else begin
      sample_q <= syncBit;
    end
  end

  // Stability filter.  Every sample that agrees with the current level clears
  // the counter, so a glitch has to be re-qualified from scratch.  The level
  // only flips once C_FILTER_LEN consecutive differing samples have been seen,
  // and the counter is cleared on the flip, so it never passes CNT_LAST.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (sample_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      filt_d = sample_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Edge decode is taken from the next filtered value so that the registered
  // pulses land in the same cycle as the new level on q_o.
  always_comb begin
    rise_d = filt_d & ~filt_q;
    fall_d = ~filt_d & filt_q;
    edge_d = rise_d | fall_d;
  end

  // Filter state.  A reset in the middle of a count simply discards it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      filt_q <= C_RESET_VAL;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  // Pulse registers.  They are cleared by reset so that forcing the level back
  // to C_RESET_VAL never produces a spurious edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
      edge_q <= edge_d;
    end
  end

  assign q_o    = filt_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign edge_o = edge_q;

endmodule

// File: rtl/sync_filter_bus.sv
// -----------------------------------------------------------------------------
// sync_filter_bus
//
// C_WIDTH independent copies of sync_filter_channel.  Each bit is synchronized
// and filtered on its own; bits are not coherent with one another, so this is
// meant for status pins, toggle-based crossings and strobes, never for data
// words.
//
// Ports:
//   clk     input   destination clock
//   rstn    input   asynchronous active-low reset
//   d       input   [C_WIDTH-1:0] asynchronous inputs
//   q       output  [C_WIDTH-1:0] synchronized, filtered levels
//   q_rise  output  [C_WIDTH-1:0] one-cycle pulses on q 0->1
//   q_fall  output  [C_WIDTH-1:0] one-cycle pulses on q 1->0
//   q_edge  output  [C_WIDTH-1:0] q_rise | q_fall
// -----------------------------------------------------------------------------
module sync_filter_bus #(
  parameter int unsigned C_WIDTH       = 1,
  parameter int unsigned C_SYNC_STAGES = 3,
  parameter int unsigned C_FILTER_LEN  = 1,
  parameter logic        C_RESET_VAL   = 1'b0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [C_WIDTH-1:0] d,
  output logic [C_WIDTH-1:0] q,
  output logic [C_WIDTH-1:0] q_rise,
  output logic [C_WIDTH-1:0] q_fall,
  output logic [C_WIDTH-1:0] q_edge
);

  // Reject configurations that cannot work: a single flop gives no
  // metastability protection and a zero-length filter has no meaning.
  if (C_WIDTH < 1) begin : g_badWidth
    $error("sync_filter_bus: C_WIDTH must be >= 1");
  end
  if (C_SYNC_STAGES < 2) begin : g_badStages
    $error("sync_filter_bus: C_SYNC_STAGES must be >= 2");
  end
  if (C_FILTER_LEN < 1) begin : g_badFilter
    $error("sync_filter_bus: C_FILTER_LEN must be >= 1");
  end

  // One self-contained channel per bit; nothing is shared between them, so
  // simultaneous events on different bits are handled independently.
  for (genvar i = 0; i < int'(C_WIDTH); i++) begin : g_chan
    sync_filter_channel #(
      .C_SYNC_STAGES (C_SYNC_STAGES),
      .C_FILTER_LEN  (C_FILTER_LEN),
      .C_RESET_VAL   (C_RESET_VAL)
    ) u_chan (
      .clk    (clk),
      .rstn   (rstn),
      .d_i    (d[i]),
      .q_o    (q[i]),
      .rise_o (q_rise[i]),
      .fall_o (q_fall[i]),
      .edge_o (q_edge[i])
    );
  end

endmodule
